fifo_reg_array_sc_flags: RTL and testbench



---
 rtl/fifo_reg_array_sc_flags.sv | 154 +++++++++++++++
 tb/tb_fifo_reg_array_sc_flags.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reg_array_sc_flags.sv
// -----------------------------------------------------------------------------
// fifo_reg_array_sc_flags
//
// Single-clock register-array FIFO with (ADDR_WIDTH+1)-bit pointers, occupancy
// flags, programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, a synchronous flush and an optional peak-depth
// watermark.
//
// Optional feature macro: FIFO_SC_WATERMARK_EN
//   defined   -> peak_depth register tracks the highest post-edge depth
//   undefined -> no register is built, peak_depth is tied to 0
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   clear        in   synchronous flush (pointers, error flags, watermark)
//   wen / ren    in   write / read requests
//   data_in      in   write data
//   data_out     out  head-of-FIFO word (show-ahead, valid when ~empty)
//   depth        out  current occupancy 0..2**ADDR_WIDTH
//   empty, full  out  occupancy flags
//   almost_empty out  depth <= AE_THRESH
//   almost_full  out  depth >= AF_THRESH
//   overflow     out  sticky: write requested while full
//   underflow    out  sticky: read requested while empty
//   peak_depth   out  high-water mark of depth (0 if watermark disabled)
// -----------------------------------------------------------------------------
module fifo_reg_array_sc_flags #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   peak_depth
);

    localparam int                 ENTRIES = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CAP_V  = (ADDR_WIDTH+1)'(ENTRIES);
    localparam logic [ADDR_WIDTH:0] AF_V   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_V   = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

    logic [ADDR_WIDTH:0] wrptr_q, wrptr_d;
    logic [ADDR_WIDTH:0] rdptr_q, rdptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic wenq;
    logic renq;
    logic mem_we;

    // Occupancy is the modular pointer difference; the extra pointer bit
    // distinguishes full (difference = ENTRIES) from empty (difference = 0).
    assign depth        = wrptr_q - rdptr_q;
    assign empty        = (depth == '0);
    assign full         = (depth == CAP_V);
    assign almost_full  = (depth >= AF_V);
    assign almost_empty = (depth <= AE_V);

    assign wenq   = wen & ~full;
    assign renq   = ren & ~empty;
    // A flush discards the concurrent write as well.
    assign mem_we = wenq & ~clear;

    assign data_out  = mem_q[rdptr_q[ADDR_WIDTH-1:0]];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        wrptr_d     = wrptr_q;
        rdptr_d     = rdptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wrptr_d     = '0;
            rdptr_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wenq) wrptr_d = wrptr_q + 1'b1;
            if (renq) rdptr_d = rdptr_q + 1'b1;
            // Error flags look at the raw request against the pre-edge state.
            if (wen & full)  overflow_d  = 1'b1;
            if (ren & empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrptr_q     <= '0;
            rdptr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrptr_q     <= wrptr_d;
            rdptr_q     <= rdptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wrptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

`ifdef FIFO_SC_WATERMARK_EN
    logic [ADDR_WIDTH:0] next_depth;
    logic [ADDR_WIDTH:0] peak_q, peak_d;

    // Track the depth that will hold after this edge, so the watermark is
    // current in the same cycle as depth itself.
    assign next_depth = wrptr_d - rdptr_d;

    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = '0;
        end else if (next_depth > peak_q) begin
            peak_d = next_depth;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_depth = peak_q;
`else
    assign peak_depth = '0;
`endif

endmodule

// File: tb/tb_fifo_reg_array_sc_flags.sv
module tb_fifo_reg_array_sc_flags;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int CAP = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          wen;
    logic          ren;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [AW:0]   depth;
    logic          empty, full, almost_empty, almost_full;
    logic          overflow, underflow;
    logic [AW:0]   peak_depth;

    fifo_reg_array_sc_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(12), .AE_THRESH(2)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .wen(wen), .ren(ren),
        .data_in(data_in), .data_out(data_out), .depth(depth),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow),
        .underflow(underflow), .peak_depth(peak_depth)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: a queue plus sticky bits and a running maximum.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf;
    int            m_peak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_peak = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        bit was_full, was_empty;
        if (c) begin
            model_reset();
            return;
        end
        was_full  = (mq.size() == CAP);
        was_empty = (mq.size() == 0);
        if (w && was_full)  m_ovf = 1;
        if (r && was_empty) m_unf = 1;
        if (r && !was_empty) void'(mq.pop_front());
        if (w && !was_full)  mq.push_back(d);
`ifdef FIFO_SC_WATERMARK_EN
        if (mq.size() > m_peak) m_peak = mq.size();
`endif
    endtask

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        wen = w; ren = r; clear = c; data_in = d;
        @(posedge clk);
        #1;
        model_step(w, r, c, d);
        wen = 0; ren = 0; clear = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".depth"}, 32'(depth), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == CAP));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mq.size() <= 2));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(mq.size() >= 12));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".peak_depth"}, 32'(peak_depth), 32'(m_peak));
        if (mq.size() != 0) chk({tag, ".data_out"}, 32'(data_out), 32'(mq[0]));
    endtask

    typedef struct {
        bit            w, r, c;
        logic [DW-1:0] d;
        int            e_depth;
        bit            e_empty, e_full, e_ovf, e_unf;
        logic [DW-1:0] e_dout;
    } vec_t;

    vec_t vt[10];

    initial begin
        // Directed vectors starting from reset; e_dout used only when non-empty.
        vt[0] = '{1,0,0,16'h1111, 1,0,0,0,0,16'h1111};
        vt[1] = '{1,0,0,16'h2222, 2,0,0,0,0,16'h1111};
        vt[2] = '{0,1,0,16'h0000, 1,0,0,0,0,16'h2222};
        vt[3] = '{1,1,0,16'h3333, 1,0,0,0,0,16'h3333};
        vt[4] = '{0,1,0,16'h0000, 0,1,0,0,0,16'h0000};
        vt[5] = '{0,1,0,16'h0000, 0,1,0,0,1,16'h0000};
        vt[6] = '{1,1,0,16'h4444, 1,0,0,0,1,16'h4444};
        vt[7] = '{1,0,1,16'h5555, 0,1,0,0,0,16'h0000};
        vt[8] = '{1,0,0,16'h6666, 1,0,0,0,0,16'h6666};
        vt[9] = '{0,1,0,16'h0000, 0,1,0,0,0,16'h0000};

        reset = 1; clear = 0; wen = 0; ren = 0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.depth_const", 32'(depth), 0);
        chk("reset.almost_empty_const", 32'(almost_empty), 1);
        reset = 0;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].w, vt[i].r, vt[i].c, vt[i].d);
            chk($sformatf("vec%0d.depth", i), 32'(depth), 32'(vt[i].e_depth));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vt[i].e_empty));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vt[i].e_full));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
            chk($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vt[i].e_unf));
            if (!vt[i].e_empty)
                chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vt[i].e_dout));
        end

        // Fill with threshold stepping, then drain in order.
        step(0, 0, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            step(1, 0, 0, DW'(k));
            chk($sformatf("fill%0d.almost_empty", k), 32'(almost_empty), 32'(k <= 2));
            chk($sformatf("fill%0d.almost_full", k), 32'(almost_full), 32'(k >= 12));
        end
        chk("fill.full", 32'(full), 1);
        chk("fill.depth", 32'(depth), 16);
        chk("fill.overflow", 32'(overflow), 0);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain%0d.data_out", k), 32'(data_out), 32'(k));
            step(0, 1, 0, 0);
        end
        chk("drain.empty", 32'(empty), 1);
        chk("drain.depth", 32'(depth), 0);

        // Empty with simultaneous wen/ren: write kept, read dropped.
        step(1, 1, 0, 16'hABCD);
        chk("empty_wr.depth", 32'(depth), 1);
        chk("empty_wr.underflow", 32'(underflow), 1);
        chk("empty_wr.data_out", 32'(data_out), 32'h0000ABCD);

        // Full with simultaneous wen/ren: read kept, write dropped.
        step(0, 0, 1, 0);
        for (int k = 1; k <= 16; k++) step(1, 0, 0, DW'(16'h0100 + k));
        step(1, 1, 0, 16'hDEAD);
        chk("full_wr.depth", 32'(depth), 15);
        chk("full_wr.overflow", 32'(overflow), 1);
        for (int k = 2; k <= 16; k++) begin
            chk($sformatf("full_drain%0d.data_out", k), 32'(data_out), 32'(16'h0100 + k));
            step(0, 1, 0, 0);
        end
        chk("full_drain.empty", 32'(empty), 1);

        // Wrap-around: 40 paired write/read at depth 3.
        step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, DW'(16'h0200 + k));
        for (int k = 3; k < 43; k++) begin
            step(1, 1, 0, DW'(16'h0200 + k));
            chk($sformatf("wrap%0d.depth", k), 32'(depth), 3);
            chk($sformatf("wrap%0d.data_out", k), 32'(data_out), 32'(16'h0200 + k - 2));
            chk($sformatf("wrap%0d.flags", k), 32'({empty, full}), 0);
        end

        // Clear at depth 7 with overflow set, concurrent write discarded.
        step(0, 0, 1, 0);
        for (int k = 0; k < 16; k++) step(1, 0, 0, DW'(k));
        step(1, 0, 0, 16'hFFFF);
        for (int k = 0; k < 9; k++) step(0, 1, 0, 0);
        chk("pre_clear.depth", 32'(depth), 7);
        chk("pre_clear.overflow", 32'(overflow), 1);
        step(1, 0, 1, 16'hBEEF);
        chk("clear.depth", 32'(depth), 0);
        chk("clear.empty", 32'(empty), 1);
        chk("clear.overflow", 32'(overflow), 0);
        chk("clear.peak_depth", 32'(peak_depth), 0);
        step(0, 0, 0, 0);
        chk("clear_next.depth", 32'(depth), 0);

        // Watermark: fill to 9, drain to 1.
        for (int k = 0; k < 9; k++) step(1, 0, 0, DW'(k));
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0);
        chk("wm.depth", 32'(depth), 1);
`ifdef FIFO_SC_WATERMARK_EN
        chk("wm.peak_depth", 32'(peak_depth), 9);
`else
        chk("wm.peak_depth", 32'(peak_depth), 0);
`endif

        // Randomised run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            int wb;
            wb = ((n / 150) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 99) < wb),
                 ($urandom_range(0, 99) < (100 - wb)),
                 ($urandom_range(0, 299) == 0),
                 DW'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset in mid-cycle takes effect without a clock edge.
        step(1, 0, 0, 16'h7777);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_model("async_reset");
        @(negedge clk);
        reset = 0;
        step(1, 0, 0, 16'h8888);
        check_model("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
